// File: rtl/sram_byte_loader.sv
// Framed byte-stream loader for SRAM port 0: A5, addr(16), count(16), data bytes [, xor checksum].
// Optional checksum stage is enabled by defining LOADER_CHECKSUM_EN.
module sram_byte_loader #(
  parameter int          ADDR_WIDTH = 11,
  parameter int          DATA_WIDTH = 16,
  parameter int          NUM_WMASKS = 2,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE, AHI, ALO, LHI, LLO, DATA, CHK, DONE
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CHK;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t                state;
  state_t                nxt;
  logic [7:0]            hi_byte;
  logic [ADDR_WIDTH:0]   baddr;
  logic [15:0]           remain;
  logic [15:0]           field;
  logic                  accept;

  assign accept = in_valid && in_ready;
  assign field  = {hi_byte, in_data};

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept && in_data == SYNC_BYTE) nxt = AHI;
      AHI:  if (accept) nxt = ALO;
      ALO:  if (accept) nxt = LHI;
      LHI:  if (accept) nxt = LLO;
      LLO:  if (accept) nxt = (field == 16'd0) ? AFTER_DATA : DATA;
      DATA: if (accept && remain == 16'd1) nxt = AFTER_DATA;
      CHK:  if (accept) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= 8'h00;
      err  <= 1'b0;
    end else if (accept) begin
      case (state)
        IDLE: if (in_data == SYNC_BYTE) begin
          csum <= 8'h00;
          err  <= 1'b0;
        end
        DATA: csum <= csum ^ in_data;
        CHK:  if (in_data != csum) err <= 1'b1;
        default: ;
      endcase
    end
  end
`else
  assign err = 1'b0;
`endif

  // Status outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi_byte     <= 8'h00;
      baddr       <= '0;
      remain      <= 16'd0;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
    end else begin
      state       <= nxt;
      in_ready    <= (nxt != DONE);
      busy        <= (nxt != IDLE);
      done        <= (nxt == DONE);
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      if (accept) begin
        case (state)
          AHI:  hi_byte <= in_data;
          ALO:  baddr   <= field[ADDR_WIDTH:0];
          LHI:  hi_byte <= in_data;
          LLO:  remain  <= field;
          DATA: begin
            // Byte address bit 0 picks the lane; little-endian within the word.
            sram_csb0   <= 1'b0;
            sram_web0   <= 1'b0;
            sram_wmask0 <= baddr[0] ? NUM_WMASKS'(2) : NUM_WMASKS'(1);
            sram_addr0  <= baddr[ADDR_WIDTH:1];
            sram_din0   <= DATA_WIDTH'({NUM_WMASKS{in_data}});
            baddr       <= baddr + {{ADDR_WIDTH{1'b0}}, 1'b1};
            remain      <= remain - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
